// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_pkg
// Description : Shared types and constants for the sequential handshake/FSM
//               blocks: FSM state encodings, the serializer's registered
//               status bundle and a counter-width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package piso_serializer_pkg;

  // Two-state handshake FSM encoding, shared with the other FSM blocks.
  typedef logic state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  // Registered status flags of the serializer, kept together so they are
  // computed and registered as one bundle.
  typedef struct packed {
    logic bit_valid;
    logic frame_done;
    logic busy;
  } piso_stat_t;

  // Bits needed to count 0..max_val inclusive (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : piso_serializer_pkg
`default_nettype wire

// File: rtl/piso_serializer_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : 0..MAX up-counter with synchronous clear and enable. The
//               count saturates at MAX and at_max flags that value.
// Ports       : clk      - clock
//               clr      - asynchronous active-high reset (count -> 0)
//               sync_clr - synchronous clear, has priority over en
//               en       - advance the count by one (holds at MAX)
//               count    - current count
//               at_max   - high when count == MAX
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
  import piso_serializer_pkg::*;
#(
  parameter int MAX   = 7,
  parameter int CNT_W = cnt_width(MAX)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sync_clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign at_max = (count_q == CNT_W'(MAX));
  assign count  = count_q;

  always_comb begin
    count_d = count_q;
    if (sync_clr) begin
      count_d = '0;
    end else if (en && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : mod_counter
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in/serial-out serializer. Accepts a (width+1)-bit
//               word through a valid/ready handshake and presents it one bit
//               per clock, starting in the cycle right after the accepting
//               edge. A word accepted while the last bit is shown streams on
//               with no idle cycle.
// Ports       : clk         - clock, rising edge
//               clr         - asynchronous active-high reset
//               parallel_in - word to serialize, sampled on an accepted load
//               load_valid  - producer offers a word
//               load_ready  - block can accept a word (combinational)
//               serial_out  - current serial bit (registered)
//               bit_valid   - serial_out carries a data bit (registered)
//               frame_done  - last bit of a word is presented (registered)
//               busy        - a frame is in progress (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int width     = 7,
  parameter bit lsb_first = 1'b0
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [width:0] parallel_in,
  input  logic           load_valid,
  output logic           load_ready,
  output logic           serial_out,
  output logic           bit_valid,
  output logic           frame_done,
  output logic           busy
);

  localparam int CNT_W = cnt_width(width);

  state_t           state_q;
  state_t           state_d;
  logic [width:0]   shreg_q;
  logic [width:0]   shreg_d;
  logic [width:0]   shreg_shifted;
  logic             serial_bit;
  piso_stat_t       stat_q;
  piso_stat_t       stat_d;

  logic [CNT_W-1:0] bit_cnt;
  logic             cnt_at_max;
  logic             last_bit;
  logic             load_fire;
  logic             in_shift;

  assign in_shift   = (state_q == ST_SHIFT);
  assign last_bit   = in_shift && cnt_at_max;
  assign load_ready = !clr && ((state_q == ST_IDLE) || last_bit);
  assign load_fire  = load_valid && load_ready;

  // Bit counter: restarts at every accepted word and also when a frame ends
  // so it rests at zero while idle.
  mod_counter #(
    .MAX   (width),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .clr      (clr),
    .sync_clr (load_fire || last_bit),
    .en       (in_shift),
    .count    (bit_cnt),
    .at_max   (cnt_at_max)
  );

  // Shift direction: the outgoing bit always sits at the register end that
  // drives serial_out; zeros fill in behind it.
  generate
    if (lsb_first) begin : g_lsb_first
      assign shreg_shifted = {1'b0, shreg_q[width:1]};
      assign serial_bit    = shreg_q[0];
    end else begin : g_msb_first
      assign shreg_shifted = {shreg_q[width-1:0], 1'b0};
      assign serial_bit    = shreg_q[width];
    end
  endgenerate

  // ---------------------------------------------------------------- FSM
  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_fire) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_bit && !load_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: status flags are computed for the coming cycle and
  // registered. frame_done is raised one edge ahead, i.e. while the
  // second-to-last bit is shown, so it lands on the last bit's cycle.
  always_comb begin
    stat_d            = '0;
    stat_d.bit_valid  = (state_d == ST_SHIFT);
    stat_d.busy       = (state_d == ST_SHIFT);
    stat_d.frame_done = in_shift && (bit_cnt == CNT_W'(width - 1));
  end

  // ----------------------------------------------------------- datapath
  // The register is cleared as the frame ends so serial_out reads 0 in IDLE.
  always_comb begin
    shreg_d = shreg_q;
    if (load_fire) begin
      shreg_d = parallel_in;
    end else if (last_bit) begin
      shreg_d = '0;
    end else if (in_shift) begin
      shreg_d = shreg_shifted;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shreg_q <= '0;
      stat_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      stat_q  <= stat_d;
    end
  end

  assign serial_out = serial_bit;
  assign bit_valid  = stat_q.bit_valid;
  assign frame_done = stat_q.frame_done;
  assign busy       = stat_q.busy;

endmodule : piso_serializer
`default_nettype wire
